// File: rtl/uart_packet_loader.sv
// Serial program loader: receives a framed, checksummed image over the UART byte stream,
// writes it to RAM, replies ACK or NAK, and holds the CPU in reset until a frame verifies.
module uart_packet_loader #(
  parameter int         ADDR_W        = 16,
  parameter int         LEN_BYTES     = 2,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter logic [7:0] ACK_BYTE      = 8'h06,
  parameter logic [7:0] NAK_BYTE      = 8'h15,
  parameter int         TIMEOUT       = 5000000,
  parameter int         RST_HOLD      = 16,
  parameter bit         BOOT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        tx_data,
  output logic              transmit,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              booting,
  output logic              cpu_rst,
  output logic              boot_rst,
  output logic              error
);
  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int LEN_W      = 8 * LEN_BYTES;
  localparam int TO_W       = $clog2(TIMEOUT + 1);
  localparam int HOLD_W     = $clog2(RST_HOLD + 1);

  typedef enum logic [3:0] {
    IDLE, URST, SYNC, ADDR, LEN, DATA, CSUM, RESP, RESP_WAIT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [7:0]          csum;
  logic [7:0]          byte_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                trig_q;
  logic                resp_ok;

  logic [ADDR_W-1:0]   addr_next;
  logic [LEN_W-1:0]    len_next;
  logic [7:0]          csum_next;
  logic                in_frame;
  logic                timeout_hit;

  // Multi-byte fields arrive MSB first, so each new byte shifts in at the bottom.
  assign addr_next   = (addr_q << 8) | ADDR_W'(rx_data);
  assign len_next    = (rem_q << 8) | LEN_W'(rx_data);
  assign csum_next   = csum + rx_data;
  assign in_frame    = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign timeout_hit = in_frame && !rx_done && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BOOT_ON_RESET ? URST : IDLE;
      booting  <= BOOT_ON_RESET;
      cpu_rst  <= BOOT_ON_RESET;
      boot_rst <= 1'b0;
      tx_data  <= '0;
      transmit <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      error    <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      csum     <= '0;
      byte_cnt <= '0;
      to_cnt   <= '0;
      hold_cnt <= '0;
      resp_ok  <= 1'b0;
      trig_q   <= trigger;
    end else begin
      trig_q   <= trigger;
      ram_we   <= 1'b0;
      transmit <= 1'b0;
      if (in_frame) to_cnt <= rx_done ? '0 : to_cnt + TO_W'(1);

      if (timeout_hit) begin
        error   <= 1'b1;
        tx_data <= NAK_BYTE;
        resp_ok <= 1'b0;
        state   <= RESP;
      end else begin
        case (state)
          IDLE: begin
            booting <= 1'b0;
            cpu_rst <= 1'b0;
            if (trigger && !trig_q) begin
              booting  <= 1'b1;
              cpu_rst  <= 1'b1;
              hold_cnt <= '0;
              state    <= URST;
            end
          end
          URST: begin
            booting <= 1'b1;
            cpu_rst <= 1'b1;
            if (hold_cnt == HOLD_W'(RST_HOLD)) begin
              boot_rst <= 1'b0;
              state    <= SYNC;
            end else begin
              boot_rst <= 1'b1;
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          SYNC: begin
            if (rx_done && rx_data == SYNC_BYTE) begin
              csum     <= '0;
              byte_cnt <= '0;
              to_cnt   <= '0;
              state    <= ADDR;
            end
          end
          ADDR: begin
            if (rx_done) begin
              addr_q <= addr_next;
              csum   <= csum_next;
              if (byte_cnt == 8'(ADDR_BYTES - 1)) begin
                byte_cnt <= '0;
                state    <= LEN;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end
          LEN: begin
            if (rx_done) begin
              rem_q <= len_next;
              csum  <= csum_next;
              if (byte_cnt == 8'(LEN_BYTES - 1)) begin
                byte_cnt <= '0;
                state    <= (len_next == '0) ? CSUM : DATA;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end
          DATA: begin
            if (rx_done) begin
              ram_we   <= 1'b1;
              ram_data <= rx_data;
              ram_addr <= addr_q;
              addr_q   <= addr_q + ADDR_W'(1);
              csum     <= csum_next;
              rem_q    <= rem_q - LEN_W'(1);
              if (rem_q == LEN_W'(1)) state <= CSUM;
            end
          end
          CSUM: begin
            if (rx_done) begin
              resp_ok <= (csum_next == 8'h00);
              tx_data <= (csum_next == 8'h00) ? ACK_BYTE : NAK_BYTE;
              error   <= (csum_next != 8'h00);
              state   <= RESP;
            end
          end
          RESP: begin
            transmit <= 1'b1;
            state    <= RESP_WAIT;
          end
          RESP_WAIT: begin
            if (tx_done) begin
              if (resp_ok) begin
                booting <= 1'b0;
                cpu_rst <= 1'b0;
                state   <= IDLE;
              end else begin
                state   <= SYNC;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_packet_loader.sv
// Directed bench for uart_packet_loader: frame loads, checksum failures, address wrap,
// zero-length frames, inter-byte timeout, trigger masking and reset during DATA.
module tb_uart_packet_loader;
  localparam int TIMEOUT  = 50;
  localparam int RST_HOLD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trigger = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        transmit;
  logic        tx_done = 1'b0;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        booting;
  logic        cpu_rst;
  logic        boot_rst;
  logic        error;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  uart_packet_loader #(
    .ADDR_W(16), .LEN_BYTES(2), .SYNC_BYTE(8'hA5), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15),
    .TIMEOUT(TIMEOUT), .RST_HOLD(RST_HOLD), .BOOT_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .transmit(transmit), .tx_done(tx_done), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_we(ram_we), .booting(booting), .cpu_rst(cpu_rst),
    .boot_rst(boot_rst), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  // A data byte must appear on the RAM port in the cycle right after its rx_done edge.
  task automatic send_wr(input string tag, input logic [7:0] b, input logic [15:0] a);
    send_byte(b);
    chk({tag, "_we"}, ram_we, 1);
    chk({tag, "_addr"}, ram_addr, a);
    chk({tag, "_data"}, ram_data, b);
  endtask

  task automatic wait_resp(input string tag, input logic [7:0] exp);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (transmit) seen = 1;
    end
    chk({tag, "_tx_seen"}, seen, 1);
    chk({tag, "_tx_data"}, tx_data, exp);
    @(negedge clk);
    chk({tag, "_tx_one_cycle"}, transmit, 0);
    chk({tag, "_tx_held"}, tx_data, exp);
    tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
  endtask

  task automatic do_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    repeat (RST_HOLD + 4) @(negedge clk);
  endtask

  task automatic count_boot_rst(input string tag);
    int hi = 0;
    int bad = 0;
    for (int i = 0; i < RST_HOLD + 10; i++) begin
      @(negedge clk);
      if (boot_rst) hi++;
      if (!booting || !cpu_rst) bad++;
    end
    chk({tag, "_boot_rst_cycles"}, hi, RST_HOLD);
    chk({tag, "_held_in_reset"}, bad, 0);
  endtask

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_booting", booting, 1);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_boot_rst", boot_rst, 0);
    chk("rst_outs", {transmit, ram_we, error, tx_data, ram_data, ram_addr}, 0);
    rst = 1'b1;
    count_boot_rst("por");

    // Good frame: sum 01+00+00+03+11+22+33 = 0x6A, checksum byte = 0x96
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h03);
    send_wr("f1_b0", 8'h11, 16'h0100);
    send_wr("f1_b1", 8'h22, 16'h0101);
    send_wr("f1_b2", 8'h33, 16'h0102);
    send_byte(8'h96);
    wait_resp("f1", 8'h06);
    @(negedge clk);
    chk("f1_booting", booting, 0);
    chk("f1_cpu_rst", cpu_rst, 0);
    chk("f1_error", error, 0);
    chk("f1_we_total", we_cnt, 3);

    // Bad checksum then a correct retry from SYNC
    do_trigger();
    chk("trig_booting", booting, 1);
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h03);
    send_wr("f2_b0", 8'h11, 16'h0100);
    send_wr("f2_b1", 8'h22, 16'h0101);
    send_wr("f2_b2", 8'h33, 16'h0102);
    send_byte(8'h97);
    wait_resp("f2", 8'h15);
    @(negedge clk);
    chk("f2_error", error, 1);
    chk("f2_still_booting", {booting, cpu_rst}, 2'b11);
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h03);
    send_wr("f3_b0", 8'h11, 16'h0100);
    send_wr("f3_b1", 8'h22, 16'h0101);
    send_wr("f3_b2", 8'h33, 16'h0102);
    send_byte(8'h96);
    wait_resp("f3", 8'h06);
    @(negedge clk);
    chk("f3_error_cleared", error, 0);
    chk("f3_released", {booting, cpu_rst}, 2'b00);

    // Address wrap: FF+FE+00+03+AA+BB+CC = 0x431, checksum byte = 0xCF
    do_trigger();
    send_byte(8'hA5);
    send_byte(8'hFF); send_byte(8'hFE);
    send_byte(8'h00); send_byte(8'h03);
    send_wr("wrap_b0", 8'hAA, 16'hFFFE);
    send_wr("wrap_b1", 8'hBB, 16'hFFFF);
    send_wr("wrap_b2", 8'hCC, 16'h0000);
    send_byte(8'hCF);
    wait_resp("wrap", 8'h06);

    // Zero-length frame: 12+34 = 0x46, checksum byte = 0xBA
    do_trigger();
    w0 = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hBA);
    wait_resp("len0", 8'h06);
    @(negedge clk);
    chk("len0_no_we", we_cnt, w0);

    // Stall after the second DATA byte; trigger toggled mid-frame must be ignored
    do_trigger();
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00); send_byte(8'h05);
    send_wr("to_b0", 8'h01, 16'h0010);
    send_wr("to_b1", 8'h02, 16'h0011);
    trigger = 1'b1;
    repeat (TIMEOUT - 2) @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    chk("to_not_early", {error, transmit}, 2'b00);
    @(negedge clk);
    chk("to_error_on_time", error, 1);
    chk("to_nak_loaded", tx_data, 8'h15);
    wait_resp("to", 8'h15);
    @(negedge clk);
    chk("to_still_booting", {booting, cpu_rst}, 2'b11);
    // Back in SYNC: a frame is accepted without a new trigger
    send_byte(8'hA5);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hBA);
    wait_resp("to_retry", 8'h06);
    @(negedge clk);
    chk("to_retry_error", error, 0);

    // Reset arriving together with a DATA byte drops the write
    do_trigger();
    send_byte(8'hA5);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h03);
    send_wr("rd_b0", 8'h55, 16'h0200);
    @(negedge clk); rx_data = 8'h66; rx_done = 1'b1; rst = 1'b0;
    @(negedge clk); rx_done = 1'b0;
    chk("rd_we_dropped", ram_we, 0);
    chk("rd_outs", {transmit, boot_rst, error, tx_data, ram_data, ram_addr}, 0);
    chk("rd_boot", {booting, cpu_rst}, 2'b11);
    rst = 1'b1;
    count_boot_rst("rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
